// File: rtl/par8_rx_pkg.sv
// Shared definitions for the 8-bit even-parity serial frame receiver.
package par8_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int         DATA_BITS = 8;
  localparam logic [7:0] ERR_MAX   = 8'hFF;

endpackage

// File: rtl/par8_xor.sv
// 8-input XOR reduction; the same function used by the downstream parity stage.
module par8_xor
  import par8_rx_pkg::*;
(
  input  logic [DATA_BITS-1:0] din,
  output logic                 dout
);

  assign dout = ^din;

endmodule

// File: rtl/par8_frame_rx.sv
// Deserialises start + 8 data (LSB first) + even parity + stop frames into bytes,
// flagging parity/framing errors and keeping a saturating error count.
module par8_frame_rx
  import par8_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // Counter counts down to zero, so loads are one less than the wait length.
  localparam logic [CW-1:0] H_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] N_LOAD = CW'(CLKS_PER_BIT - 1);

  rx_state_e                state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               bit_q, bit_d;
  logic [DATA_BITS-1:0]     sr_q, sr_d;
  logic                     par_q, par_d;
  logic [7:0]               data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic [7:0]               err_q, err_d;

  logic tick;
  logic sr_par;
  logic perr_now;
  logic ferr_now;

  par8_xor u_xor (
    .din  (sr_q),
    .dout (sr_par)
  );

  assign tick     = (cnt_q == '0);
  assign perr_now = par_q ^ sr_par;
  assign ferr_now = ~rxd;

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - CW'(1);
    bit_d   = bit_q;
    sr_d    = sr_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!rxd) begin
          state_d = ST_START;
          cnt_d   = H_LOAD;
          bit_d   = 3'd0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rxd) begin
            state_d = ST_DATA;
            cnt_d   = N_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          sr_d  = {rxd, sr_q[DATA_BITS-1:1]};
          cnt_d = N_LOAD;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (tick) begin
          par_d   = rxd;
          cnt_d   = N_LOAD;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          data_d  = sr_q;
          perr_d  = perr_now;
          ferr_d  = ferr_now;
          valid_d = 1'b1;
          if ((perr_now | ferr_now) && (err_q != ERR_MAX)) err_d = err_q + 8'd1;
          // A low stop bit may be a break; wait for the line to recover first.
          state_d = rxd ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxd) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      err_q   <= err_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_par8_frame_rx.sv
// Scoreboard bench: the driver queues the expected result of each frame, a
// monitor pops and checks it whenever valid is seen.
module tb_par8_frame_rx;
  import par8_rx_pkg::*;

  localparam int N = 4;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic [7:0] err_count;

  par8_frame_rx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic [7:0] errc;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_err  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: valid is registered, so sampling at the falling edge is stable.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_valid: got valid with data %0h, expected none (cycle %0d)", data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("data",       32'(data),       32'(e.data));
        chk("parity_err", 32'(parity_err), 32'(e.perr));
        chk("frame_err",  32'(frame_err),  32'(e.ferr));
        chk("err_count",  32'(err_count),  32'(e.errc));
        chk("valid_time", 32'(cyc),        32'(e.cyc));
      end
    end
  end

  // Called on a falling edge; the next rising edge sees the start bit (t0),
  // and valid is raised by the edge at t0+H+10N.
  task automatic send_frame(input logic [7:0] b, input logic p, input logic s);
    exp_t        e;
    logic [10:0] bits;
    bits   = {s, p, b, 1'b0};
    e.data = b;
    e.perr = p ^ (^b);
    e.ferr = ~s;
    if ((e.perr || e.ferr) && m_err != 255) m_err++;
    e.errc = 8'(m_err);
    e.cyc  = cyc + 1 + H + 10 * N;
    q.push_back(e);
    for (int i = 0; i < 11; i++) begin
      rxd = bits[i];
      repeat (N) @(negedge clk);
    end
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    m_err = 0;
    chk("rst_data",       32'(data),        32'd0);
    chk("rst_valid",      32'(valid),       32'd0);
    chk("rst_parity_err", 32'(parity_err),  32'd0);
    chk("rst_frame_err",  32'(frame_err),   32'd0);
    chk("rst_err_count",  32'(err_count),   32'd0);
    chk("rst_state",      32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Good frame, then parity error, then corrected parity.
    send_frame(8'hA5, 1'b0, 1'b1);
    drain();
    do_reset();
    send_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    drain();

    // Framing error with a held-low break, then a clean frame.
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (N) @(negedge clk);
    send_frame(8'h11, 1'b0, 1'b1);
    drain();

    // One-cycle glitch on an idle line.
    do_reset();
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_idle", 32'(dut.state_q), 32'(ST_IDLE));
    repeat (50) @(negedge clk);

    // All byte values back to back, then bad parity until saturation.
    do_reset();
    for (int b = 0; b < 256; b++) send_frame(8'(b), ^(8'(b)), 1'b1);
    for (int k = 0; k < 300; k++) send_frame(8'(k), ~^(8'(k)), 1'b1);
    drain();
    chk("err_saturated", 32'(err_count), 32'd255);

    // Reset part way through d4 of 0xFF aborts the frame silently.
    do_reset();
    rxd = 1'b0;
    repeat (N) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * N + 2) @(negedge clk);
    do_reset();
    repeat (3) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1);
    drain();
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
